// File: rtl/gpio_link_rx.sv
// Receive end of the 4-beat GPIO message link: oversamples link_clk/valid/data, reassembles a message.
// Optional odd-parity checking on each beat is enabled by defining GPIO_LINK_RX_PARITY_EN.
module gpio_link_rx #(
  parameter int NUM_WORDS   = 4,
  parameter int WORD_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          link_clk,
  input  logic                          link_valid,
  input  logic [WORD_W-1:0]             link_data,
`ifdef GPIO_LINK_RX_PARITY_EN
  input  logic                          link_par,
  output logic                          parity_err,
`endif
  output logic                          link_rdy,
  output logic [NUM_WORDS*WORD_W-1:0]   msg_out,
  output logic                          msg_valid,
  input  logic                          msg_ack,
  output logic                          frag_err,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  logic [SYNC_STAGES-1:0]             r_clk_sync;
  logic [SYNC_STAGES-1:0]             r_vld_sync;
  logic [SYNC_STAGES-1:0][WORD_W-1:0] r_dat_sync;
  logic                               r_clk_prev;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [IDX_W-1:0]                   r_idx;
  logic [IDX_W-1:0]                   w_idx_nxt;
  logic [NUM_WORDS-1:0][WORD_W-1:0]   r_words;
  logic                               r_frag;
  logic                               r_ovr;

  logic                               w_beat;
  logic                               w_vld;
  logic [WORD_W-1:0]                  w_dat;
  logic                               w_par_ok;
  logic                               w_wr;
  logic                               w_frag_set;
  logic                               w_ovr_set;
  logic                               w_par_set;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= '0;
      r_vld_sync <= '0;
      r_dat_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], link_clk};
      r_vld_sync <= {r_vld_sync[SYNC_STAGES-2:0], link_valid};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], link_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  // Falling edge of the synced link clock: data was launched on the rise, so it is settled here.
  assign w_beat = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_vld  = r_vld_sync[SYNC_STAGES-1];
  assign w_dat  = r_dat_sync[SYNC_STAGES-1];

`ifdef GPIO_LINK_RX_PARITY_EN
  logic [SYNC_STAGES-1:0] r_par_sync;
  logic                   r_perr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_par_sync <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_par_sync <= {r_par_sync[SYNC_STAGES-2:0], link_par};
      if (w_par_set) r_perr <= 1'b1;
    end
  end

  assign w_par_ok   = ^{w_dat, r_par_sync[SYNC_STAGES-1]};
  assign parity_err = r_perr;
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr        = 1'b0;
    w_frag_set  = 1'b0;
    w_ovr_set   = 1'b0;
    w_par_set   = 1'b0;
    case (r_state)
      IDLE, RECV: begin
        if (w_beat && w_vld) begin
          if (!w_par_ok) begin
            w_par_set   = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_wr = 1'b1;
            if (r_idx == IDX_W'(NUM_WORDS-1)) begin
              w_idx_nxt   = '0;
              w_state_nxt = HOLD;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_state_nxt = RECV;
            end
          end
        end else if (w_beat && r_state == RECV) begin
          w_frag_set  = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        // A beat here is always dropped, even when the ack lands in the same cycle.
        if (w_beat && w_vld) w_ovr_set = 1'b1;
        if (msg_ack) begin
          w_idx_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_words <= '0;
      r_frag  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      for (int i = 0; i < NUM_WORDS; i++)
        if (w_wr && r_idx == IDX_W'(i)) r_words[i] <= w_dat;
      if (w_frag_set) r_frag <= 1'b1;
      if (w_ovr_set)  r_ovr  <= 1'b1;
    end
  end

  assign msg_valid = (r_state == HOLD);
  assign link_rdy  = (r_state != HOLD);
  assign msg_out   = r_words;
  assign frag_err  = r_frag;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_gpio_link_rx.sv
// Bench for gpio_link_rx: vector table, hand-written corner sequences, then random beats vs. a message model.
module tb_gpio_link_rx;
  localparam int NW = 4, W = 32, SS = 2, MW = NW*W;

  logic          clock = 1'b0, resetn = 1'b0;
  logic          link_clk = 1'b0, link_valid = 1'b0, msg_ack = 1'b0;
  logic [W-1:0]  link_data = '0;
  logic          link_rdy, msg_valid, frag_err, overrun;
  logic [MW-1:0] msg_out;
`ifdef GPIO_LINK_RX_PARITY_EN
  logic          link_par = 1'b1;
  logic          parity_err;
`endif

  int n_chk = 0, n_err = 0;

  gpio_link_rx #(.NUM_WORDS(NW), .WORD_W(W), .SYNC_STAGES(SS)) dut (
    .clock(clock), .resetn(resetn), .link_clk(link_clk), .link_valid(link_valid),
    .link_data(link_data),
`ifdef GPIO_LINK_RX_PARITY_EN
    .link_par(link_par), .parity_err(parity_err),
`endif
    .link_rdy(link_rdy), .msg_out(msg_out), .msg_valid(msg_valid), .msg_ack(msg_ack),
    .frag_err(frag_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Message-level model: collected words, how many gathered so far, whether a message is pending.
  logic [W-1:0] m_words [NW];
  int           m_cnt;
  bit           m_pend, m_frag, m_ovr, m_perr;

  function automatic logic [MW-1:0] m_msg();
    logic [MW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*W +: W] = m_words[i];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NW; i++) m_words[i] = '0;
    m_cnt = 0; m_pend = 0; m_frag = 0; m_ovr = 0; m_perr = 0;
  endtask

  task automatic m_beat(input logic v, input logic [W-1:0] d, input bit bad);
    if (m_pend) begin
      if (v) m_ovr = 1;
    end else if (v) begin
      if (bad) begin
        m_perr = 1; m_cnt = 0;
      end else begin
        m_words[m_cnt] = d;
        m_cnt++;
        if (m_cnt == NW) begin m_pend = 1; m_cnt = 0; end
      end
    end else if (m_cnt != 0) begin
      m_frag = 1; m_cnt = 0;
    end
  endtask

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " msg_valid"}, MW'(msg_valid), MW'(m_pend));
    check({tag, " link_rdy"},  MW'(link_rdy),  MW'(!m_pend));
    check({tag, " frag_err"},  MW'(frag_err),  MW'(m_frag));
    check({tag, " overrun"},   MW'(overrun),   MW'(m_ovr));
    check({tag, " msg_out"},   msg_out,        m_msg());
`ifdef GPIO_LINK_RX_PARITY_EN
    check({tag, " parity_err"}, MW'(parity_err), MW'(m_perr));
`endif
  endtask

  // Rise launches data; 6-cycle phases satisfy the SYNC_STAGES+2 minimum.
  task automatic launch(input logic v, input logic [W-1:0] d, input bit bad);
    @(negedge clock);
    link_clk = 1'b1; link_valid = v; link_data = d;
`ifdef GPIO_LINK_RX_PARITY_EN
    link_par = (~^d) ^ bad;
`endif
    repeat (6) @(negedge clock);
    link_clk = 1'b0;
  endtask

  task automatic do_beat(input logic v, input logic [W-1:0] d, input bit bad);
    launch(v, d, bad);
    repeat (6) @(negedge clock);
    m_beat(v, d, bad);
  endtask

  task automatic do_ack();
    @(negedge clock); msg_ack = 1'b1;
    @(negedge clock); msg_ack = 1'b0;
    m_pend = 0;
  endtask

  typedef struct {
    bit            is_ack;
    logic          v;
    logic [W-1:0]  d;
    logic          mv, rdy, frag, ovr;
    bit            chk_msg;
    logic [MW-1:0] msg;
  } tv_t;

  tv_t tv[$];

  function automatic tv_t mk(bit a, logic v, logic [W-1:0] d, logic mv, logic rdy,
                             logic fr, logic ov, bit cm, logic [MW-1:0] m);
    tv_t t;
    t.is_ack = a; t.v = v; t.d = d; t.mv = mv; t.rdy = rdy; t.frag = fr; t.ovr = ov;
    t.chk_msg = cm; t.msg = m;
    return t;
  endfunction

  initial begin
    logic [MW-1:0] msg1, msga, msgc, msgd, msge;
    msg1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    msga = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    msgc = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    msgd = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    msge = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};

    tv.push_back(mk(0, 1, 32'h11111111, 0, 1, 0, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'h22222222, 0, 1, 0, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'h33333333, 0, 1, 0, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'h44444444, 1, 0, 0, 0, 1, msg1));
    tv.push_back(mk(1, 0, '0,           0, 1, 0, 0, 1, msg1));
    tv.push_back(mk(0, 1, 32'hB0B0B0B0, 0, 1, 0, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'hB1B1B1B1, 0, 1, 0, 0, 0, '0));
    tv.push_back(mk(0, 0, 32'h0,        0, 1, 1, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'hA0A0A0A0, 0, 1, 1, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'hA1A1A1A1, 0, 1, 1, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'hA2A2A2A2, 0, 1, 1, 0, 0, '0));
    tv.push_back(mk(0, 1, 32'hA3A3A3A3, 1, 0, 1, 0, 1, msga));
    tv.push_back(mk(0, 1, 32'hDEADBEEF, 1, 0, 1, 1, 1, msga));
    tv.push_back(mk(1, 0, '0,           0, 1, 1, 1, 1, msga));
    tv.push_back(mk(0, 1, 32'hC0C0C0C0, 0, 1, 1, 1, 0, '0));
    tv.push_back(mk(0, 1, 32'hC1C1C1C1, 0, 1, 1, 1, 0, '0));
    tv.push_back(mk(0, 1, 32'hC2C2C2C2, 0, 1, 1, 1, 0, '0));
    tv.push_back(mk(0, 1, 32'hC3C3C3C3, 1, 0, 1, 1, 1, msgc));
    tv.push_back(mk(1, 0, '0,           0, 1, 1, 1, 1, msgc));

    m_reset();
    repeat (3) @(negedge clock);
    check("reset msg_valid", MW'(msg_valid), '0);
    check("reset link_rdy",  MW'(link_rdy),  MW'(1));
    check("reset msg_out",   msg_out,        '0);
    check("reset frag_err",  MW'(frag_err),  '0);
    check("reset overrun",   MW'(overrun),   '0);
    resetn = 1'b1;

    foreach (tv[k]) begin
      if (tv[k].is_ack) do_ack();
      else do_beat(tv[k].v, tv[k].d, 0);
      check($sformatf("tv%0d msg_valid", k), MW'(msg_valid), MW'(tv[k].mv));
      check($sformatf("tv%0d link_rdy", k),  MW'(link_rdy),  MW'(tv[k].rdy));
      check($sformatf("tv%0d frag_err", k),  MW'(frag_err),  MW'(tv[k].frag));
      check($sformatf("tv%0d overrun", k),   MW'(overrun),   MW'(tv[k].ovr));
      if (tv[k].chk_msg) check($sformatf("tv%0d msg_out", k), msg_out, tv[k].msg);
    end

    // Reset after two beats of a message: everything returns to reset values at once.
    do_beat(1, 32'h55555555, 0);
    do_beat(1, 32'h66666666, 0);
    @(negedge clock); resetn = 1'b0;
    #1;
    m_reset();
    check("midrst msg_valid", MW'(msg_valid), '0);
    check("midrst link_rdy",  MW'(link_rdy),  MW'(1));
    check("midrst msg_out",   msg_out,        '0);
    check("midrst frag_err",  MW'(frag_err),  '0);
    check("midrst overrun",   MW'(overrun),   '0);
    @(negedge clock); resetn = 1'b1;
    for (int i = 0; i < NW; i++) do_beat(1, msge[i*W +: W], 0);
    check("fresh msg_out", msg_out, msge);
    check("fresh word0",   MW'(msg_out[W-1:0]), MW'(32'hE0E0E0E0));
    check("fresh msg_valid", MW'(msg_valid), MW'(1));
    do_ack();

    // Latency: msg_valid rises on the SS+1-th edge after the final fall is first sampled.
    for (int i = 0; i < NW-1; i++) do_beat(1, msgd[i*W +: W], 0);
    launch(1, msgd[(NW-1)*W +: W], 0);
    for (int e = 1; e <= SS+1; e++) begin
      @(negedge clock);
      check($sformatf("latency edge%0d", e), MW'(msg_valid), MW'(e == SS+1));
    end
    repeat (6-(SS+1)) @(negedge clock);
    m_beat(1, msgd[(NW-1)*W +: W], 0);
    check_model("latency");

    // Ack and an overrun beat in the same cycle: ack wins, beat dropped, overrun still set.
    launch(1, 32'hEEEEEEEE, 0);
    repeat (SS) @(negedge clock);
    msg_ack = 1'b1;
    @(negedge clock);
    msg_ack = 1'b0;
    m_pend = 0; m_ovr = 1;
    check_model("ack+beat");
    check("ack+beat msg_out", msg_out, msgd);
    repeat (6-(SS+1)) @(negedge clock);
    for (int i = 0; i < NW; i++) do_beat(1, msgc[i*W +: W], 0);
    check_model("after ack+beat");
    do_ack();

`ifdef GPIO_LINK_RX_PARITY_EN
    @(negedge clock); resetn = 1'b0;
    @(negedge clock); resetn = 1'b1;
    m_reset();
    do_beat(1, 32'h12345678, 0);
    do_beat(1, 32'h9ABCDEF0, 1);
    check("par parity_err", MW'(parity_err), MW'(1));
    check("par msg_valid",  MW'(msg_valid),  '0);
    for (int i = 0; i < NW; i++) do_beat(1, msga[i*W +: W], 0);
    check("par recover msg_out", msg_out, msga);
    check_model("par recover");
    do_ack();
`endif

    for (int s = 0; s < 400; s++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) do_beat(logic'($urandom_range(0, 9) != 0), W'($urandom), 0);
      else if (r < 9) do_ack();
      else repeat (int'($urandom_range(1, 4))) @(negedge clock);
      check_model($sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
